// File: rtl/led_pattern_encoder.sv
// Debounced 7-segment pattern to 4-bit code encoder with a valid/ready output handshake.
// Optional illegal-pattern counter port err_cnt, enabled by defining PAT_ERR_CNT_EN.
module led_pattern_encoder #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] pat,
  input  logic       ready,
  output logic [3:0] code,
  output logic       valid,
  output logic       err,
  output logic       ovr
`ifdef PAT_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned PAT_W  = 7;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned STB_W  = 8;
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [PAT_W-1:0]  p1, last, last_d;
  logic [STB_W-1:0]  stb, stb_d;
  logic              acc, acc_d;
  logic [0:0]        state, state_d;
  logic [CODE_W-1:0] code_d;
  logic              valid_d, err_d, ovr_d;
  logic              live, legal;
  logic [CODE_W-1:0] map_code;

  // Legal pattern lookup: returns {legal, code}.
  function automatic logic [CODE_W:0] map_pat(input logic [PAT_W-1:0] p);
    case (p)
      7'b0000000: map_pat = {1'b1, 4'd0};
      7'b1000000: map_pat = {1'b1, 4'd1};
      7'b0100000: map_pat = {1'b1, 4'd2};
      7'b0010000: map_pat = {1'b1, 4'd3};
      7'b0001000: map_pat = {1'b1, 4'd4};
      7'b0000100: map_pat = {1'b1, 4'd5};
      7'b0000010: map_pat = {1'b1, 4'd6};
      7'b0000001: map_pat = {1'b1, 4'd7};
      7'b1111111: map_pat = {1'b1, 4'd8};
      7'b1111110: map_pat = {1'b1, 4'd9};
      7'b1111101: map_pat = {1'b1, 4'd10};
      7'b1111011: map_pat = {1'b1, 4'd11};
      7'b0110111: map_pat = {1'b1, 4'd12};
      7'b1101111: map_pat = {1'b1, 4'd13};
      7'b1011111: map_pat = {1'b1, 4'd14};
      7'b0111111: map_pat = {1'b1, 4'd15};
      default:    map_pat = {1'b0, 4'd0};
    endcase
  endfunction

  // Stability counter; acc marks the single edge where it first reaches its cap.
  always_comb begin
    stb_d = stb;
    acc_d = 1'b0;
    if (pat != p1) begin
      stb_d = '0;
    end else if (stb != STB_MAX) begin
      stb_d = stb + STB_W'(1);
    end
    acc_d = (stb_d == STB_MAX) && (stb != STB_MAX);
  end

  // Handshake FSM and output next-state; accepts matching the last pattern are dropped.
  always_comb begin
    state_d  = state;
    code_d   = code;
    err_d    = 1'b0;
    ovr_d    = ovr;
    last_d   = last;
    {legal, map_code} = map_pat(p1);
    live     = acc && (p1 != last);
    if (live) begin
      last_d = p1;
      err_d  = !legal;
    end
    case (state)
      S_IDLE: begin
        if (live && legal) begin
          state_d = S_HOLD;
          code_d  = map_code;
        end
      end
      S_HOLD: begin
        if (live && legal) begin
          code_d = map_code;
          if (!ready) ovr_d = 1'b1;
        end else if (ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1    <= '0;
      stb   <= '0;
      acc   <= 1'b0;
      last  <= '0;
      state <= S_IDLE;
      code  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      p1    <= pat;
      stb   <= stb_d;
      acc   <= acc_d;
      last  <= last_d;
      state <= state_d;
      code  <= code_d;
      valid <= valid_d;
      err   <= err_d;
      ovr   <= ovr_d;
    end
  end

`ifdef PAT_ERR_CNT_EN
  // Saturating count of illegal accepts, stepping together with err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_d && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_led_pattern_encoder.sv
// Self-checking bench for led_pattern_encoder: vector table, corner sequences, random vs model.
module tb_led_pattern_encoder;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] pat;
  logic       ready;
  logic [3:0] code;
  logic       valid;
  logic       err;
  logic       ovr;
`ifdef PAT_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  led_pattern_encoder #(.DEBOUNCE(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pat    (pat),
    .ready  (ready),
    .code   (code),
    .valid  (valid),
    .err    (err),
    .ovr    (ovr)
`ifdef PAT_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a pattern seen D consecutive samples is accepted, visible one edge later.
  logic [6:0] legal_pats [16];
  int         m_code, m_cnt, m_run;
  logic       m_valid, m_err, m_ovr, m_pend;
  logic [6:0] m_last, m_prev, m_pend_pat;

  function automatic int lookup(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 16; i++) if (legal_pats[i] == p) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_code = 0; m_cnt = 0; m_valid = 0; m_err = 0; m_ovr = 0;
    m_last = '0; m_prev = '0; m_run = 1; m_pend = 0; m_pend_pat = '0;
  endtask

  task automatic model_edge(input logic [6:0] p, input logic r);
    bit loaded = 0;
    int idx;
    m_err = 0;
    if (m_pend && m_pend_pat != m_last) begin
      m_last = m_pend_pat;
      idx = lookup(m_pend_pat);
      if (idx >= 0) begin
        if (m_valid && !r) m_ovr = 1;
        m_code = idx;
        m_valid = 1;
        loaded = 1;
      end else begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (!loaded && m_valid && r) m_valid = 0;
    if (p == m_prev) m_run++; else m_run = 1;
    m_prev = p;
    m_pend = (m_run == D);
    m_pend_pat = p;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".code"}, 32'(code), 32'(m_code));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
`ifdef PAT_ERR_CNT_EN
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
  endtask

  // Drive inputs just after an edge, take the next edge, sample 1 ns later.
  task automatic step(input logic [6:0] p, input logic r);
    pat = p;
    ready = r;
    @(posedge clk);
    #1;
    model_edge(p, r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pat = '0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [6:0] pat;
    logic       ready;
    logic [3:0] code;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t tbl [18];
  int   vcount;

  initial begin
    legal_pats = '{7'b0000000, 7'b1000000, 7'b0100000, 7'b0010000,
                   7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001,
                   7'b1111111, 7'b1111110, 7'b1111101, 7'b1111011,
                   7'b0110111, 7'b1101111, 7'b1011111, 7'b0111111};
    for (int i = 0; i < 4; i++) tbl[i] = '{7'b0010000, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{7'b0010000, 1'b1, 4'd3, 1'b1, 1'b0};
    tbl[5]  = '{7'b0010000, 1'b1, 4'd3, 1'b0, 1'b0};
    for (int i = 6; i < 10; i++) tbl[i] = '{7'b1010101, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[10] = '{7'b1010101, 1'b1, 4'd3, 1'b0, 1'b1};
    tbl[11] = '{7'b1010101, 1'b1, 4'd3, 1'b0, 1'b0};
    for (int i = 12; i < 16; i++) tbl[i] = '{7'b0000000, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[16] = '{7'b0000000, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[17] = '{7'b0000000, 1'b1, 4'd0, 1'b0, 1'b0};

    // Reset state, including immediate async clear.
    rst_n = 1'b0; pat = '0; ready = 1'b0;
    #2;
    chk("rst.code", 32'(code), 0);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.ovr", 32'(ovr), 0);
`ifdef PAT_ERR_CNT_EN
    chk("rst.err_cnt", 32'(err_cnt), 0);
`endif
    do_reset();

    // Vector table: legal encode/handshake, illegal pattern, all-off code after another pattern.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].pat, tbl[i].ready);
      chk($sformatf("tbl%0d.code", i), 32'(code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d.valid", i), 32'(valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d.ovr", i), 32'(ovr), 0);
    end
`ifdef PAT_ERR_CNT_EN
    chk("tbl.err_cnt", 32'(err_cnt), 1);
`endif

    // Bounce rejection: only the final stable hold produces a code.
    do_reset();
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step(((i / 2) % 2 == 0) ? 7'b0001000 : 7'b0000000, 1'b1);
      if (valid) vcount++;
      cmp_model("bounce");
    end
    for (int i = 1; i <= 7; i++) begin
      step(7'b0001000, 1'b1);
      if (valid) vcount++;
      if (i == 5) begin
        chk("bounce.code", 32'(code), 4);
        chk("bounce.valid", 32'(valid), 1);
      end
      cmp_model("bounce_hold");
    end
    chk("bounce.count", 32'(vcount), 1);

    // Overwrite while pending, then drain.
    do_reset();
    repeat (6) step(7'b1111111, 1'b0);
    chk("ovw.code8", 32'(code), 8);
    chk("ovw.ovr0", 32'(ovr), 0);
    repeat (6) step(7'b0110111, 1'b0);
    chk("ovw.code12", 32'(code), 12);
    chk("ovw.valid", 32'(valid), 1);
    chk("ovw.ovr1", 32'(ovr), 1);
    step(7'b0110111, 1'b1);
    chk("ovw.drain", 32'(valid), 0);
    chk("ovw.sticky", 32'(ovr), 1);

    // Duplicate suppression across a one-cycle glitch.
    do_reset();
    vcount = 0;
    for (int i = 1; i <= 6; i++) begin
      step(7'b0000001, 1'b1);
      if (i == 5) chk("dup.code7", 32'(code), 7);
    end
    step(7'b0000000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(7'b0000001, 1'b1);
      if (valid) vcount++;
      cmp_model("dup");
    end
    chk("dup.none", 32'(vcount), 0);

    // Reset in HOLD clears at once; code re-emitted DEBOUNCE+1 edges after release.
    do_reset();
    repeat (6) step(7'b0111111, 1'b0);
    chk("rmid.code", 32'(code), 15);
    chk("rmid.valid", 32'(valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rmid.clr_code", 32'(code), 0);
    chk("rmid.clr_valid", 32'(valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 5; i++) begin
      step(7'b0111111, 1'b0);
      if (i == 4) chk("rmid.early", 32'(valid), 0);
      cmp_model("rmid");
    end
    chk("rmid.reemit_code", 32'(code), 15);
    chk("rmid.reemit_valid", 32'(valid), 1);

`ifdef PAT_ERR_CNT_EN
    // Counter saturation over 300 alternating illegal patterns.
    do_reset();
    for (int i = 0; i < 300; i++) repeat (D + 1) step((i % 2 == 0) ? 7'b1010101 : 7'b1100110, 1'b1);
    chk("sat.err_cnt", 32'(err_cnt), 255);
`endif

    // Random patterns and ready against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [6:0] p;
      int sel = int'($urandom_range(0, 3));
      int hold = int'($urandom_range(1, 7));
      if (sel < 2) p = legal_pats[$urandom_range(0, 15)];
      else if (sel == 2) p = 7'($urandom);
      else p = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'b1010101;
      for (int h = 0; h < hold; h++) begin
        step(p, 1'($urandom_range(0, 1)));
        cmp_model("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_encoder.md
LED_PATTERN_ENCODER -- requirements
Module: led_pattern_encoder

Interface
REQ-001 Parameter DEBOUNCE, default 4, is the number of consecutive clocks PAT must hold before it is accepted; legal range is 2..255.
REQ-002 CLK  input  1  is the single system clock; all registers update on its rising edge.
REQ-003 RST  input  1  is the reset, asynchronous and active-low.
REQ-004 PAT  input  7  is the raw 7-segment LED pattern to be encoded, asynchronous to any handshake.
REQ-005 READY  input  1  is the consumer ready; a code transfers when VALID and READY are both high at a clock edge.
REQ-006 CODE  output  4  is the encoded 4-bit code, registered.
REQ-007 VALID  output  1  indicates that CODE holds an unconsumed code.
REQ-008 ERR  output  1  is a one-clock pulse that flags an accepted pattern with no legal code.
REQ-009 OVR  output  1  is a sticky flag that a pending code was overwritten before it was consumed.
REQ-010 ERR_CNT  output  8  is the illegal-pattern count; this port is present only under REQ-027.

Function
REQ-011 The legal map (PAT -> CODE) SHALL be: 0000000->0, 1000000->1, 0100000->2, 0010000->3, 0001000->4, 0000100->5, 0000010->6, 0000001->7, 1111111->8, 1111110->9, 1111101->10, 1111011->11, 0110111->12, 1101111->13, 1011111->14, 0111111->15.
REQ-012 Every other PAT value is illegal.
REQ-013 PAT SHALL be registered once into P1 each clock, with no further synchronizer inside the block.
REQ-014 Stability counter STB behaviour:
- Clears to 0 when PAT != P1.
- Otherwise increments, saturating at DEBOUNCE-1.
REQ-015 An accept event SHALL occur on the clock where STB transitions to DEBOUNCE-1; it fires exactly once per stable period.
REQ-016 An accept event SHALL be ignored when P1 equals the last accepted pattern LAST, so no duplicate codes are produced.
REQ-017 On a non-ignored accept event the block SHALL do the following:
- Update LAST to P1.
- If P1 is legal: load CODE from the map and set VALID.
- If P1 is illegal: pulse ERR for one clock and leave CODE and VALID unchanged.
REQ-018 With PAT changed and held stable from edge k, VALID (or ERR) SHALL rise at edge k+DEBOUNCE+1.
REQ-019 State machine states and transitions:
- IDLE: VALID=0.
- IDLE -> HOLD on a legal accept.
- HOLD: VALID=1 and CODE frozen.
- HOLD -> IDLE when READY=1.
REQ-020 VALID SHALL be deasserted on the edge on which VALID and READY are both high.
REQ-021 A legal accept in HOLD without READY SHALL overwrite CODE with the new value, keep VALID=1, and set OVR.
REQ-022 A legal accept on the same edge as a HOLD transfer SHALL load the new CODE and keep VALID=1, without setting OVR.
REQ-023 READY while in IDLE SHALL have no effect.
REQ-024 OVR SHALL clear only on reset.

Reset
REQ-025 While RST=0 the block SHALL hold the following values:
- CODE=0, VALID=0, ERR=0, OVR=0.
- STB=0, P1=0000000.
- LAST=0000000, so an all-off pattern after reset produces no code.
- ERR_CNT=0.
- State IDLE.
REQ-026 A reset asserted mid-debounce or in HOLD SHALL discard the pending code; after release, the first new stable pattern follows REQ-018 from the release edge.

Configuration
REQ-027 With macro PAT_ERR_CNT_EN defined, ERR_CNT SHALL exist and increment on every ERR pulse, saturating at 255.
REQ-028 Without PAT_ERR_CNT_EN, the ERR_CNT port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-029 Legal encode and handshake (DEBOUNCE=4, READY=1): PAT=0010000 held from edge 0 -> CODE=3 and VALID=1 at edge 5; VALID=0 at edge 6.
REQ-030 Bounce rejection: PAT toggles 0001000/0000000 every 2 clocks for 20 clocks, then holds 0001000 -> exactly one code, CODE=4, 5 edges after the final change.
REQ-031 Illegal pattern: PAT=1010101 stable -> a single ERR pulse, VALID stays 0; with PAT_ERR_CNT_EN, ERR_CNT=1 and saturates at 255 after 300 alternating illegal patterns.
REQ-032 Overwrite: with READY=0, accept 1111111 (CODE=8) then 0110111 -> CODE=12, VALID=1, OVR=1; READY=1 -> VALID=0 and OVR stays 1.
REQ-033 Duplicate suppression: PAT=0000001 stable, then 1 clock of 0000000, then 0000001 again -> the first code is 7; the 1-clock glitch never reaches DEBOUNCE, so the return produces no second code.
REQ-034 Reset mid-operation: RST low for 1 clock while VALID=1 and CODE=15 -> all outputs 0 immediately; after release, PAT=0111111 held -> CODE=15 re-emitted at release+DEBOUNCE+1.
